// File: rtl/rs_alu_pkg.sv
// rtl/rs_alu_pkg.sv - shared widths, ALU op encodings and tag-match helper
package rs_alu_pkg;

  localparam int ROB_SIZE_WIDTH       = 4;
  localparam int CALC_OP_L1_NUM_WIDTH = 3;
  localparam int RS_SIZE_DFLT         = 8;

  // ALU major opcodes; the decoder, this block and the ALU all use these
  typedef enum logic [CALC_OP_L1_NUM_WIDTH-1:0] {
    OP_L1_ADD  = 3'd0,
    OP_L1_SLL  = 3'd1,
    OP_L1_SLT  = 3'd2,
    OP_L1_SLTU = 3'd3,
    OP_L1_XOR  = 3'd4,
    OP_L1_SR   = 3'd5,
    OP_L1_OR   = 3'd6,
    OP_L1_AND  = 3'd7
  } op_l1_e;

  // Minor select: add vs sub, srl vs sra
  localparam logic OP_L2_ADD = 1'b0;
  localparam logic OP_L2_SUB = 1'b1;
  localparam logic OP_L2_SRL = 1'b0;
  localparam logic OP_L2_SRA = 1'b1;

  function automatic logic tag_hit(input logic bc_ready,
                                   input logic [ROB_SIZE_WIDTH-1:0] bc_tag,
                                   input logic [ROB_SIZE_WIDTH-1:0] tag);
    return bc_ready && (bc_tag == tag);
  endfunction

endpackage

// File: rtl/rs_alu_if.sv
// rtl/rs_alu_if.sv - dispatch, broadcast and ALU issue bundle for rs_alu
interface rs_alu_if;
  import rs_alu_pkg::*;

  logic                            disp_valid_in;
  logic [CALC_OP_L1_NUM_WIDTH-1:0] disp_op_L1_in;
  logic                            disp_op_L2_in;
  logic [ROB_SIZE_WIDTH-1:0]       disp_rob_id_in;
  logic [31:0]                     disp_v1_in;
  logic [31:0]                     disp_v2_in;
  logic                            disp_q1_pend_in;
  logic                            disp_q2_pend_in;
  logic [ROB_SIZE_WIDTH-1:0]       disp_q1_in;
  logic [ROB_SIZE_WIDTH-1:0]       disp_q2_in;
  logic                            full_out;

  logic                            alu_bc_ready_in;
  logic [ROB_SIZE_WIDTH-1:0]       alu_bc_rob_id_in;
  logic [31:0]                     alu_bc_value_in;
  logic                            lsb_bc_ready_in;
  logic [ROB_SIZE_WIDTH-1:0]       lsb_bc_rob_id_in;
  logic [31:0]                     lsb_bc_value_in;

  logic                            alu_valid_out;
  logic [31:0]                     alu_opr1_out;
  logic [31:0]                     alu_opr2_out;
  logic [ROB_SIZE_WIDTH-1:0]       alu_rob_id_out;
  logic [CALC_OP_L1_NUM_WIDTH-1:0] alu_op_L1_out;
  logic                            alu_op_L2_out;

  modport master (
    output disp_valid_in, disp_op_L1_in, disp_op_L2_in, disp_rob_id_in,
           disp_v1_in, disp_v2_in, disp_q1_pend_in, disp_q2_pend_in,
           disp_q1_in, disp_q2_in,
           alu_bc_ready_in, alu_bc_rob_id_in, alu_bc_value_in,
           lsb_bc_ready_in, lsb_bc_rob_id_in, lsb_bc_value_in,
    input  full_out, alu_valid_out, alu_opr1_out, alu_opr2_out,
           alu_rob_id_out, alu_op_L1_out, alu_op_L2_out
  );

  modport slave (
    input  disp_valid_in, disp_op_L1_in, disp_op_L2_in, disp_rob_id_in,
           disp_v1_in, disp_v2_in, disp_q1_pend_in, disp_q2_pend_in,
           disp_q1_in, disp_q2_in,
           alu_bc_ready_in, alu_bc_rob_id_in, alu_bc_value_in,
           lsb_bc_ready_in, lsb_bc_rob_id_in, lsb_bc_value_in,
    output full_out, alu_valid_out, alu_opr1_out, alu_opr2_out,
           alu_rob_id_out, alu_op_L1_out, alu_op_L2_out
  );

endinterface

// File: rtl/rs_alu_prio_enc.sv
// rtl/rs_alu_prio_enc.sv - lowest-set-index priority encoder with found flag
module prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan downward so the lowest set bit is the last one to win
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_alu.sv
// rtl/rs_alu.sv - ALU reservation station: dispatch, operand wakeup, in-order-by-index issue
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DFLT,
  parameter int IDX_W   = $clog2(RS_SIZE)
) (
  input logic     clk_in,
  input logic     rst_n_in,
  input logic     rdy_in,
  input logic     need_flush_in,
  rs_alu_if.slave bus
);

  logic [RS_SIZE-1:0]              busy;
  logic [RS_SIZE-1:0]              p1;
  logic [RS_SIZE-1:0]              p2;
  logic [RS_SIZE-1:0]              op_l2;
  logic [CALC_OP_L1_NUM_WIDTH-1:0] op_l1  [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0]       rob_id [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0]       q1     [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0]       q2     [RS_SIZE];
  logic [31:0]                     v1     [RS_SIZE];
  logic [31:0]                     v2     [RS_SIZE];

  logic [RS_SIZE-1:0] ready_vec;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               free_found;
  logic               sel_found;
  logic               disp_we;
  logic               advance;
  logic [31:0]        disp_val1;
  logic [31:0]        disp_val2;
  logic               disp_pend1;
  logic               disp_pend2;

  assign advance      = rdy_in && !need_flush_in;
  assign disp_we      = bus.disp_valid_in && free_found;
  assign ready_vec    = busy & ~p1 & ~p2;
  assign bus.full_out = &busy;

  prio_enc #(.N(RS_SIZE), .W(IDX_W)) u_free_sel (
    .req   (~busy),
    .idx   (free_idx),
    .found (free_found)
  );

  prio_enc #(.N(RS_SIZE), .W(IDX_W)) u_issue_sel (
    .req   (ready_vec),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // Same-cycle bypass for dispatched operands; ALU bus wins over LSB bus
  always_comb begin
    disp_val1  = bus.disp_v1_in;
    disp_pend1 = bus.disp_q1_pend_in;
    disp_val2  = bus.disp_v2_in;
    disp_pend2 = bus.disp_q2_pend_in;
    if (bus.disp_q1_pend_in) begin
      if (tag_hit(bus.alu_bc_ready_in, bus.alu_bc_rob_id_in, bus.disp_q1_in)) begin
        disp_val1  = bus.alu_bc_value_in;
        disp_pend1 = 1'b0;
      end else if (tag_hit(bus.lsb_bc_ready_in, bus.lsb_bc_rob_id_in, bus.disp_q1_in)) begin
        disp_val1  = bus.lsb_bc_value_in;
        disp_pend1 = 1'b0;
      end
    end
    if (bus.disp_q2_pend_in) begin
      if (tag_hit(bus.alu_bc_ready_in, bus.alu_bc_rob_id_in, bus.disp_q2_in)) begin
        disp_val2  = bus.alu_bc_value_in;
        disp_pend2 = 1'b0;
      end else if (tag_hit(bus.lsb_bc_ready_in, bus.lsb_bc_rob_id_in, bus.disp_q2_in)) begin
        disp_val2  = bus.lsb_bc_value_in;
        disp_pend2 = 1'b0;
      end
    end
  end

  // Busy bits: flush clears all; dispatch fills a pre-edge free slot, issue frees the selected one
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy <= '0;
    end else if (need_flush_in) begin
      busy <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (disp_we && free_idx == IDX_W'(i)) begin
          busy[i] <= 1'b1;
        end else if (sel_found && sel_idx == IDX_W'(i)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  // Entry payload: dispatch write, else snoop both broadcasts for pending operands
  always_ff @(posedge clk_in) begin
    if (advance) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (disp_we && free_idx == IDX_W'(i)) begin
          op_l1[i]  <= bus.disp_op_L1_in;
          op_l2[i]  <= bus.disp_op_L2_in;
          rob_id[i] <= bus.disp_rob_id_in;
          q1[i]     <= bus.disp_q1_in;
          q2[i]     <= bus.disp_q2_in;
          v1[i]     <= disp_val1;
          v2[i]     <= disp_val2;
          p1[i]     <= disp_pend1;
          p2[i]     <= disp_pend2;
        end else if (busy[i]) begin
          if (p1[i] && tag_hit(bus.alu_bc_ready_in, bus.alu_bc_rob_id_in, q1[i])) begin
            v1[i] <= bus.alu_bc_value_in;
            p1[i] <= 1'b0;
          end else if (p1[i] && tag_hit(bus.lsb_bc_ready_in, bus.lsb_bc_rob_id_in, q1[i])) begin
            v1[i] <= bus.lsb_bc_value_in;
            p1[i] <= 1'b0;
          end
          if (p2[i] && tag_hit(bus.alu_bc_ready_in, bus.alu_bc_rob_id_in, q2[i])) begin
            v2[i] <= bus.alu_bc_value_in;
            p2[i] <= 1'b0;
          end else if (p2[i] && tag_hit(bus.lsb_bc_ready_in, bus.lsb_bc_rob_id_in, q2[i])) begin
            v2[i] <= bus.lsb_bc_value_in;
            p2[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Issue register toward the ALU; payload holds when nothing is ready
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.alu_valid_out  <= 1'b0;
      bus.alu_opr1_out   <= '0;
      bus.alu_opr2_out   <= '0;
      bus.alu_rob_id_out <= '0;
      bus.alu_op_L1_out  <= '0;
      bus.alu_op_L2_out  <= 1'b0;
    end else if (need_flush_in) begin
      bus.alu_valid_out <= 1'b0;
    end else if (rdy_in) begin
      bus.alu_valid_out <= sel_found;
      if (sel_found) begin
        bus.alu_opr1_out   <= v1[sel_idx];
        bus.alu_opr2_out   <= v2[sel_idx];
        bus.alu_rob_id_out <= rob_id[sel_idx];
        bus.alu_op_L1_out  <= op_l1[sel_idx];
        bus.alu_op_L2_out  <= op_l2[sel_idx];
      end
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// tb/tb_rs_alu.sv - self-checking bench for rs_alu with a reference model
module tb_rs_alu;
  import rs_alu_pkg::*;

  logic clk_in        = 1'b0;
  logic rst_n_in      = 1'b0;
  logic rdy_in        = 1'b1;
  logic need_flush_in = 1'b0;

  rs_alu_if bus();

  rs_alu #(.RS_SIZE(8), .IDX_W(3)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .rdy_in        (rdy_in),
    .need_flush_in (need_flush_in),
    .bus           (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a table of waiting ops plus the last issued op
  typedef struct {
    bit        busy;
    bit        p1, p2;
    bit [2:0]  l1;
    bit        l2;
    bit [3:0]  rob, q1, q2;
    bit [31:0] v1, v2;
  } ent_t;

  ent_t      m [8];
  bit        e_valid;
  bit [31:0] e_opr1, e_opr2;
  bit [3:0]  e_rob;
  bit [2:0]  e_l1;
  bit        e_l2;
  int        m_sel, m_fr, m_cnt;
  bit [32:0] s;

  function automatic bit [32:0] snoop(input bit [3:0] tag);
    if (bus.alu_bc_ready_in && bus.alu_bc_rob_id_in == tag) return {1'b1, bus.alu_bc_value_in};
    if (bus.lsb_bc_ready_in && bus.lsb_bc_rob_id_in == tag) return {1'b1, bus.lsb_bc_value_in};
    return '0;
  endfunction

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
      e_valid = 0; e_opr1 = 0; e_opr2 = 0; e_rob = 0; e_l1 = 0; e_l2 = 0;
    end else if (need_flush_in) begin
      for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
      e_valid = 0;
    end else if (rdy_in) begin
      m_sel = -1; m_fr = -1;
      for (int i = 7; i >= 0; i--) begin
        if (m[i].busy && !m[i].p1 && !m[i].p2) m_sel = i;
        if (!m[i].busy) m_fr = i;
      end
      e_valid = (m_sel >= 0);
      if (m_sel >= 0) begin
        e_opr1 = m[m_sel].v1; e_opr2 = m[m_sel].v2; e_rob = m[m_sel].rob;
        e_l1 = m[m_sel].l1; e_l2 = m[m_sel].l2;
        m[m_sel].busy = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
        if (m[i].busy && m[i].p1) begin
          s = snoop(m[i].q1);
          if (s[32]) begin m[i].v1 = s[31:0]; m[i].p1 = 0; end
        end
        if (m[i].busy && m[i].p2) begin
          s = snoop(m[i].q2);
          if (s[32]) begin m[i].v2 = s[31:0]; m[i].p2 = 0; end
        end
      end
      if (bus.disp_valid_in && m_fr >= 0) begin
        m[m_fr].busy = 1; m[m_fr].l1 = bus.disp_op_L1_in; m[m_fr].l2 = bus.disp_op_L2_in;
        m[m_fr].rob = bus.disp_rob_id_in; m[m_fr].q1 = bus.disp_q1_in; m[m_fr].q2 = bus.disp_q2_in;
        m[m_fr].v1 = bus.disp_v1_in; m[m_fr].v2 = bus.disp_v2_in;
        m[m_fr].p1 = bus.disp_q1_pend_in; m[m_fr].p2 = bus.disp_q2_pend_in;
        if (bus.disp_q1_pend_in) begin
          s = snoop(bus.disp_q1_in);
          if (s[32]) begin m[m_fr].v1 = s[31:0]; m[m_fr].p1 = 0; end
        end
        if (bus.disp_q2_pend_in) begin
          s = snoop(bus.disp_q2_in);
          if (s[32]) begin m[m_fr].v2 = s[31:0]; m[m_fr].p2 = 0; end
        end
      end
    end
  end

  // Compare DUT against the model every cycle, mid-period
  always @(negedge clk_in) begin
    if (cmp_en) begin
      m_cnt = 0;
      for (int i = 0; i < 8; i++) m_cnt += int'(m[i].busy);
      chk("cmp_valid", bus.alu_valid_out, e_valid);
      chk("cmp_opr1", bus.alu_opr1_out, e_opr1);
      chk("cmp_opr2", bus.alu_opr2_out, e_opr2);
      chk("cmp_rob", bus.alu_rob_id_out, e_rob);
      chk("cmp_l1", bus.alu_op_L1_out, e_l1);
      chk("cmp_l2", bus.alu_op_L2_out, e_l2);
      chk("cmp_full", bus.full_out, m_cnt == 8);
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic disp(input bit [2:0] l1, input bit l2, input bit [3:0] rob,
                      input bit [31:0] v1, input bit [31:0] v2,
                      input bit p1, input bit [3:0] q1, input bit p2, input bit [3:0] q2);
    bus.disp_valid_in = 1; bus.disp_op_L1_in = l1; bus.disp_op_L2_in = l2;
    bus.disp_rob_id_in = rob; bus.disp_v1_in = v1; bus.disp_v2_in = v2;
    bus.disp_q1_pend_in = p1; bus.disp_q1_in = q1; bus.disp_q2_pend_in = p2; bus.disp_q2_in = q2;
  endtask

  task automatic quiet();
    bus.disp_valid_in = 0; bus.alu_bc_ready_in = 0; bus.lsb_bc_ready_in = 0;
  endtask

  task automatic alu_bc(input bit [3:0] rob, input bit [31:0] val);
    bus.alu_bc_ready_in = 1; bus.alu_bc_rob_id_in = rob; bus.alu_bc_value_in = val;
  endtask

  initial begin
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    quiet();
    bus.alu_bc_rob_id_in = 0; bus.alu_bc_value_in = 0;
    bus.lsb_bc_rob_id_in = 0; bus.lsb_bc_value_in = 0;
    repeat (3) step();
    rst_n_in = 1;
    cmp_en   = 1;
    chk("rst_valid", bus.alu_valid_out, 0);
    chk("rst_opr1", bus.alu_opr1_out, 0);
    chk("rst_rob", bus.alu_rob_id_out, 0);
    chk("rst_full", bus.full_out, 0);
    step();

    // Simple issue: ADD 5,7 -> rob 3
    disp(OP_L1_ADD, OP_L2_ADD, 3, 5, 7, 0, 0, 0, 0);
    step(); quiet();
    chk("simple_n_valid", bus.alu_valid_out, 0);
    step();
    chk("simple_valid", bus.alu_valid_out, 1);
    chk("simple_opr1", bus.alu_opr1_out, 5);
    chk("simple_opr2", bus.alu_opr2_out, 7);
    chk("simple_rob", bus.alu_rob_id_out, 3);
    step();
    chk("simple_n2_valid", bus.alu_valid_out, 0);

    // Wakeup: SUB waits on rob 2, broadcast two cycles later
    disp(OP_L1_ADD, OP_L2_SUB, 4, 0, 1, 1, 2, 0, 0);
    step(); quiet();
    step();
    alu_bc(2, 32'h10);
    step(); quiet();
    chk("wake_no_same_edge", bus.alu_valid_out, 0);
    step();
    chk("wake_valid", bus.alu_valid_out, 1);
    chk("wake_opr1", bus.alu_opr1_out, 32'h10);
    chk("wake_opr2", bus.alu_opr2_out, 1);
    chk("wake_l2", bus.alu_op_L2_out, 1);

    // Bypass: dispatch waiting on rob 5 while LSB broadcasts rob 5
    disp(OP_L1_XOR, 0, 6, 2, 0, 0, 0, 1, 5);
    bus.lsb_bc_ready_in = 1; bus.lsb_bc_rob_id_in = 5; bus.lsb_bc_value_in = 32'hFF;
    step(); quiet();
    step();
    chk("byp_valid", bus.alu_valid_out, 1);
    chk("byp_opr2", bus.alu_opr2_out, 32'hFF);
    chk("byp_l1", bus.alu_op_L1_out, OP_L1_XOR);
    step();

    // Fill all eight entries waiting on rob 9, then try a ninth
    for (int i = 0; i < 8; i++) begin
      disp(OP_L1_ADD, 0, 4'(i), 0, 32'(i), 1, 9, 0, 0);
      step();
    end
    chk("fill_full", bus.full_out, 1);
    disp(OP_L1_ADD, 0, 15, 1, 1, 0, 0, 0, 0);
    step(); quiet();
    chk("ninth_full", bus.full_out, 1);
    chk("ninth_valid", bus.alu_valid_out, 0);
    alu_bc(9, 32'h99);
    step(); quiet();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("order_valid", bus.alu_valid_out, 1);
      chk("order_rob", bus.alu_rob_id_out, 32'(i));
      chk("order_opr1", bus.alu_opr1_out, 32'h99);
      if (i == 0) chk("order_full_drop", bus.full_out, 0);
    end
    step();
    chk("ninth_dropped", bus.alu_valid_out, 0);

    // Stall: rdy_in low holds outputs and a pending ready entry
    disp(OP_L1_ADD, 0, 1, 11, 22, 0, 0, 0, 0);
    step();
    disp(OP_L1_OR, 0, 2, 33, 44, 0, 0, 0, 0);
    step(); quiet();
    rdy_in = 0;
    chk("stall_pre_rob", bus.alu_rob_id_out, 1);
    repeat (3) begin
      step();
      chk("stall_valid", bus.alu_valid_out, 1);
      chk("stall_opr1", bus.alu_opr1_out, 11);
    end
    rdy_in = 1;
    step();
    chk("stall_resume_rob", bus.alu_rob_id_out, 2);
    chk("stall_resume_opr1", bus.alu_opr1_out, 33);
    step();

    // Flush with four waiting entries and a concurrent ready dispatch
    for (int i = 0; i < 4; i++) begin
      disp(OP_L1_ADD, 0, 4'(8 + i), 0, 0, 1, 12, 0, 0);
      step();
    end
    disp(OP_L1_ADD, 0, 13, 1, 1, 0, 0, 0, 0);
    need_flush_in = 1;
    step(); quiet();
    need_flush_in = 0;
    chk("flush_valid", bus.alu_valid_out, 0);
    chk("flush_full", bus.full_out, 0);
    alu_bc(12, 5);
    step(); quiet();
    repeat (3) begin
      step();
      chk("flush_no_issue", bus.alu_valid_out, 0);
    end

    // Asynchronous reset mid-run with three waiting entries
    for (int i = 0; i < 3; i++) begin
      disp(OP_L1_ADD, 0, 4'(13), 0, 0, 1, 14, 0, 0);
      step();
    end
    disp(OP_L1_AND, 0, 7, 3, 4, 0, 0, 0, 0);
    step(); quiet();
    step();
    chk("prerst_valid", bus.alu_valid_out, 1);
    #2 rst_n_in = 0;
    #1;
    chk("async_rst_valid", bus.alu_valid_out, 0);
    chk("async_rst_full", bus.full_out, 0);
    chk("async_rst_rob", bus.alu_rob_id_out, 0);
    step();
    rst_n_in = 1;
    alu_bc(14, 32'h77);
    step(); quiet();
    repeat (3) begin
      step();
      chk("postrst_no_issue", bus.alu_valid_out, 0);
    end

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
